// File: rtl/sti_pkg.sv
// Shared definitions for the STI receive path.
//   STI_LEN8..STI_LEN32 : frame length codes (8/16/24/32 bits)
//   sti_len_bits(code)  : number of data bits for a length code
//   sti_len_mask(code)  : right-justified mask of the valid data bits
//   sti_rx_state_t      : receiver FSM state; ST_PAR exists only when
//                         STI_RX_PARITY_EN is defined.
package sti_pkg;

  localparam logic [1:0] STI_LEN8  = 2'd0;
  localparam logic [1:0] STI_LEN16 = 2'd1;
  localparam logic [1:0] STI_LEN24 = 2'd2;
  localparam logic [1:0] STI_LEN32 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
`ifdef STI_RX_PARITY_EN
    ST_PAR   = 2'd2,
`endif
    ST_DRAIN = 2'd3
  } sti_rx_state_t;

  // N = 8 * (code + 1)
  function automatic logic [5:0] sti_len_bits(input logic [1:0] code);
    return {1'b0, code, 3'b000} + 6'd8;
  endfunction

  function automatic logic [31:0] sti_len_mask(input logic [1:0] code);
    logic [31:0] m;
    case (code)
      STI_LEN8:  m = 32'h0000_00FF;
      STI_LEN16: m = 32'h0000_FFFF;
      STI_LEN24: m = 32'h00FF_FFFF;
      default:   m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sti_rx_shifter.sv
// Shift register and bit counter for the STI receiver.
//   start      : first bit of a frame; latches cfg_length/cfg_msb, clears sh,
//                captures bit 0 and sets the count to 1
//   shift_en   : capture one further bit
//   si_data    : serial bit
//   cfg_length : length code, sampled on start only
//   cfg_msb    : 1 = MSB-first insertion, 0 = LSB-first, sampled on start only
//   sh         : assembled bits (right-justified, unused bits 0)
//   len_q      : latched length code of the current frame
//   last       : high in the cycle whose capture completes the frame
module sti_rx_shifter
  import sti_pkg::*;
#(
  parameter int unsigned LEN_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             shift_en,
  input  logic             si_data,
  input  logic [LEN_W-1:0] cfg_length,
  input  logic             cfg_msb,
  output logic [31:0]      sh,
  output logic [LEN_W-1:0] len_q,
  output logic             last
);

  logic [5:0] cnt;
  logic       msb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh    <= '0;
      cnt   <= '0;
      len_q <= '0;
      msb_q <= 1'b0;
    end else if (start) begin
      len_q <= cfg_length;
      msb_q <= cfg_msb;
      // Bit 0 lands at sh[0] for both orders; the rest is cleared so that
      // bits above N stay zero.
      sh    <= {31'b0, si_data};
      cnt   <= 6'd1;
    end else if (shift_en) begin
      cnt <= cnt + 6'd1;
      if (msb_q) begin
        sh <= {sh[30:0], si_data};
      end else begin
        sh[cnt[4:0]] <= si_data;
      end
    end
  end

  // The capture in progress is bit number cnt (0-based); it is the last
  // one when cnt + 1 equals N.
  assign last = shift_en && ((cnt + 6'd1) == sti_len_bits(2'(len_q)));

endmodule

// File: rtl/sti_rx.sv
// STI serial-to-parallel receiver.
// Samples si_data while si_valid is high, reassembles 8/16/24/32-bit words
// (MSB- or LSB-first), and offers them on a valid/ready holding register.
// Optional feature macro: STI_RX_PARITY_EN (one even-parity bit per frame).
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   si_data, si_valid    : serial bit and frame strobe
//   cfg_length, cfg_msb  : frame length code and bit order (first bit only)
//   po_data, po_length   : held word (right-justified) and its length code
//   po_valid, po_ready   : holding register handshake
//   err_short/long/ovr/par : sticky error flags
//   err_clr              : one-cycle clear of the sticky flags
module sti_rx
  import sti_pkg::*;
#(
  parameter int unsigned LEN_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             si_data,
  input  logic             si_valid,
  input  logic [LEN_W-1:0] cfg_length,
  input  logic             cfg_msb,
  output logic [31:0]      po_data,
  output logic [LEN_W-1:0] po_length,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             err_short,
  output logic             err_long,
  output logic             err_ovr,
  output logic             err_par,
  input  logic             err_clr
);

  sti_rx_state_t    state, state_next;
  logic [31:0]      sh;
  logic [31:0]      data_masked;
  logic [LEN_W-1:0] len_q;
  logic             last;
  logic             start, shift_en;
  logic             done_set, done_q;
  logic             short_set, long_set, ovr_set, load;

  sti_rx_shifter #(.LEN_W(LEN_W)) u_shifter (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .shift_en   (shift_en),
    .si_data    (si_data),
    .cfg_length (cfg_length),
    .cfg_msb    (cfg_msb),
    .sh         (sh),
    .len_q      (len_q),
    .last       (last)
  );

  assign data_masked = sh & sti_len_mask(2'(len_q));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (si_valid) state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (!si_valid) state_next = ST_IDLE;
`ifdef STI_RX_PARITY_EN
        else if (last) state_next = ST_PAR;
`else
        else if (last) state_next = ST_DRAIN;
`endif
      end
`ifdef STI_RX_PARITY_EN
      ST_PAR:   state_next = si_valid ? ST_DRAIN : ST_IDLE;
`endif
      ST_DRAIN: if (!si_valid) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  logic par_bad;
  always_comb begin
    start     = (state == ST_IDLE) && si_valid;
    shift_en  = (state == ST_SHIFT) && si_valid;
    long_set  = (state == ST_DRAIN) && si_valid;
    short_set = (state == ST_SHIFT) && !si_valid;
    par_bad   = 1'b0;
`ifdef STI_RX_PARITY_EN
    if (state == ST_PAR) begin
      short_set = !si_valid;
      par_bad   = si_valid && (si_data != ^data_masked);
    end
    done_set  = (state == ST_PAR) && si_valid;
`else
    done_set  = last;
`endif
  end

  // done is registered so the load sees the completed shift register.
  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= done_set;
  end

  assign load    = done_q && (!po_valid || po_ready);
  assign ovr_set = done_q && po_valid && !po_ready;

  // Holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      po_data   <= '0;
      po_length <= '0;
      po_valid  <= 1'b0;
    end else if (load) begin
      po_data   <= data_masked;
      po_length <= len_q;
      po_valid  <= 1'b1;
    end else if (po_ready) begin
      po_valid  <= 1'b0;
    end
  end

  // Sticky errors: a set on the same edge as err_clr wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_ovr   <= 1'b0;
    end else begin
      err_short <= short_set | (err_short & ~err_clr);
      err_long  <= long_set  | (err_long  & ~err_clr);
      err_ovr   <= ovr_set   | (err_ovr   & ~err_clr);
    end
  end

`ifdef STI_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) err_par <= 1'b0;
    else       err_par <= par_bad | (err_par & ~err_clr);
  end
`else
  assign err_par = 1'b0;
`endif

endmodule

// File: tb/tb_sti_rx.sv
// Directed self-checking bench for sti_rx. Inputs change 1 ns after the
// rising edge; outputs are sampled at the same point.
module tb_sti_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        si_data, si_valid;
  logic [1:0]  cfg_length;
  logic        cfg_msb;
  logic [31:0] po_data;
  logic [1:0]  po_length;
  logic        po_valid, po_ready;
  logic        err_short, err_long, err_ovr, err_par, err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  sti_rx #(.LEN_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .si_data    (si_data),
    .si_valid   (si_valid),
    .cfg_length (cfg_length),
    .cfg_msb    (cfg_msb),
    .po_data    (po_data),
    .po_length  (po_length),
    .po_valid   (po_valid),
    .po_ready   (po_ready),
    .err_short  (err_short),
    .err_long   (err_long),
    .err_ovr    (err_ovr),
    .err_par    (err_par),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame of 8*(code+1) bits (plus even parity in the parity
  // build), then 'extra' further strobe cycles. Config inputs are scrambled
  // after the first bit since the receiver must ignore them there.
  task automatic send_frame(input logic [31:0] val, input logic [1:0] code,
                            input logic msb, input int unsigned extra);
    int unsigned n;
    logic p;
    n = 8 * (int'(code) + 1);
    p = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      si_valid   = 1'b1;
      cfg_length = (i == 0) ? code : ~code;
      cfg_msb    = (i == 0) ? msb : ~msb;
      si_data    = msb ? val[n-1-i] : val[i];
      p          = p ^ si_data;
      tick();
    end
`ifdef STI_RX_PARITY_EN
    si_data = p;
    tick();
`endif
    for (int unsigned i = 0; i < extra; i++) begin
      si_data = 1'b1;
      tick();
    end
    si_valid = 1'b0;
    si_data  = 1'b0;
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({po_data, po_length, po_valid, err_short, err_long, err_ovr, err_par} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h len=%0d v=%b errs=%b%b%b%b, expected all 0",
               po_data, po_length, po_valid, err_short, err_long, err_ovr, err_par);
    end
  endtask

  task automatic test_msb8();
    po_ready = 1'b1;
    send_frame(32'h0000_00B2, 2'd0, 1'b1, 0);
    n_checks++;
    if (po_valid !== 1'b0) begin
      n_fail++; $display("FAIL msb8_early_valid: got %b expected 0", po_valid);
    end
    tick();
    n_checks++;
    if (po_valid !== 1'b1) begin
      n_fail++; $display("FAIL msb8_valid: got %b expected 1", po_valid);
    end
    n_checks++;
    if (po_data !== 32'h0000_00B2) begin
      n_fail++; $display("FAIL msb8_data: got %h expected 000000b2", po_data);
    end
    n_checks++;
    if (po_length !== 2'd0) begin
      n_fail++; $display("FAIL msb8_length: got %0d expected 0", po_length);
    end
    tick();
    n_checks++;
    if (po_valid !== 1'b0) begin
      n_fail++; $display("FAIL msb8_valid_drop: got %b expected 0", po_valid);
    end
  endtask

  task automatic test_lsb32();
    po_ready = 1'b1;
    send_frame(32'hDEAD_BEEF, 2'd3, 1'b0, 0);
    tick();
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 32'hDEAD_BEEF || po_length !== 2'd3) begin
      n_fail++;
      $display("FAIL lsb32_word: got v=%b data=%h len=%0d expected v=1 data=deadbeef len=3",
               po_valid, po_data, po_length);
    end
    n_checks++;
    if ({err_short, err_long, err_ovr, err_par} !== 4'b0000) begin
      n_fail++;
      $display("FAIL lsb32_errs: got %b%b%b%b expected 0000", err_short, err_long, err_ovr, err_par);
    end
    tick();
  endtask

  task automatic test_short();
    logic [15:0] v;
    po_ready = 1'b1;
    v = 16'hABCD;
    for (int unsigned i = 0; i < 10; i++) begin
      si_valid   = 1'b1;
      cfg_length = 2'd1;
      cfg_msb    = 1'b1;
      si_data    = v[15-i];
      tick();
    end
    si_valid = 1'b0;
    tick();
    n_checks++;
    if (err_short !== 1'b1) begin
      n_fail++; $display("FAIL short_flag: got %b expected 1", err_short);
    end
    tick();
    n_checks++;
    if (po_valid !== 1'b0) begin
      n_fail++; $display("FAIL short_no_word: got po_valid=%b expected 0", po_valid);
    end
    send_frame(32'h0000_005A, 2'd0, 1'b1, 0);
    tick();
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 32'h0000_005A) begin
      n_fail++; $display("FAIL short_next_word: got v=%b data=%h expected v=1 data=0000005a",
                         po_valid, po_data);
    end
    clear_errors();
    n_checks++;
    if (err_short !== 1'b0) begin
      n_fail++; $display("FAIL short_clear: got %b expected 0", err_short);
    end
  endtask

  task automatic test_long();
    po_ready = 1'b0;
    send_frame(32'h00C3_A5F0, 2'd2, 1'b1, 3);
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 32'h00C3_A5F0 || po_length !== 2'd2) begin
      n_fail++; $display("FAIL long_word: got v=%b data=%h len=%0d expected v=1 data=00c3a5f0 len=2",
                         po_valid, po_data, po_length);
    end
    n_checks++;
    if (err_long !== 1'b1 || err_ovr !== 1'b0) begin
      n_fail++; $display("FAIL long_flag: got long=%b ovr=%b expected long=1 ovr=0", err_long, err_ovr);
    end
    clear_errors();
    n_checks++;
    if (err_long !== 1'b0) begin
      n_fail++; $display("FAIL long_clear: got %b expected 0", err_long);
    end
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 32'h00C3_A5F0) begin
      n_fail++; $display("FAIL long_hold: got v=%b data=%h expected v=1 data=00c3a5f0", po_valid, po_data);
    end
    po_ready = 1'b1;
    tick();
    n_checks++;
    if (po_valid !== 1'b0) begin
      n_fail++; $display("FAIL long_accept: got po_valid=%b expected 0", po_valid);
    end
  endtask

  task automatic test_overrun();
    po_ready = 1'b0;
    send_frame(32'h0000_0011, 2'd0, 1'b0, 0);
    tick();
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 32'h0000_0011) begin
      n_fail++; $display("FAIL ovr_first: got v=%b data=%h expected v=1 data=00000011", po_valid, po_data);
    end
    send_frame(32'h0000_0022, 2'd0, 1'b0, 0);
    tick();
    n_checks++;
    if (po_data !== 32'h0000_0011 || err_ovr !== 1'b1) begin
      n_fail++; $display("FAIL ovr_drop: got data=%h ovr=%b expected data=00000011 ovr=1", po_data, err_ovr);
    end
    po_ready = 1'b1;
    tick();
    n_checks++;
    if (po_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovr_accept: got po_valid=%b expected 0", po_valid);
    end
    clear_errors();
  endtask

  task automatic test_back_to_back();
    po_ready = 1'b1;
    send_frame(32'h0000_003C, 2'd0, 1'b1, 0);
    tick();
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 32'h0000_003C) begin
      n_fail++; $display("FAIL b2b_first: got v=%b data=%h expected v=1 data=0000003c", po_valid, po_data);
    end
    send_frame(32'h0000_81C3, 2'd1, 1'b0, 0);
    tick();
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 32'h0000_81C3 || po_length !== 2'd1) begin
      n_fail++; $display("FAIL b2b_second: got v=%b data=%h len=%0d expected v=1 data=000081c3 len=1",
                         po_valid, po_data, po_length);
    end
    n_checks++;
    if ({err_short, err_long, err_ovr} !== 3'b000) begin
      n_fail++; $display("FAIL b2b_errs: got %b%b%b expected 000", err_short, err_long, err_ovr);
    end
    tick();
  endtask

  task automatic test_parity();
`ifdef STI_RX_PARITY_EN
    logic [7:0] v;
    po_ready = 1'b1;
    v = 8'h03;
    for (int unsigned i = 0; i < 8; i++) begin
      si_valid   = 1'b1;
      cfg_length = 2'd0;
      cfg_msb    = 1'b1;
      si_data    = v[7-i];
      tick();
    end
    si_data = 1'b1;
    tick();
    si_valid = 1'b0;
    si_data  = 1'b0;
    tick();
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 32'h0000_0003 || err_par !== 1'b1) begin
      n_fail++; $display("FAIL par_bad: got v=%b data=%h par=%b expected v=1 data=00000003 par=1",
                         po_valid, po_data, err_par);
    end
    tick();
    clear_errors();
`else
    po_ready = 1'b1;
    send_frame(32'h0000_0003, 2'd0, 1'b1, 0);
    tick();
    n_checks++;
    if (err_par !== 1'b0 || po_data !== 32'h0000_0003) begin
      n_fail++; $display("FAIL par_off: got par=%b data=%h expected par=0 data=00000003", err_par, po_data);
    end
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    po_ready = 1'b0;
    send_frame(32'h0000_00A5, 2'd0, 1'b1, 0);
    tick();
    for (int unsigned i = 0; i < 4; i++) begin
      si_valid = 1'b1; cfg_length = 2'd0; si_data = 1'b1;
      tick();
    end
    si_valid = 1'b0;
    tick();
    n_checks++;
    if (po_valid !== 1'b1 || err_short !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_setup: got v=%b short=%b expected v=1 short=1", po_valid, err_short);
    end
    for (int unsigned i = 0; i < 5; i++) begin
      si_valid = 1'b1; cfg_length = 2'd1; si_data = 1'b1;
      tick();
    end
    reset = 1'b1;
    tick();
    si_valid = 1'b0;
    n_checks++;
    if ({po_data, po_length, po_valid, err_short, err_long, err_ovr, err_par} !== 39'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got data=%h len=%0d v=%b errs=%b%b%b%b expected all 0",
                         po_data, po_length, po_valid, err_short, err_long, err_ovr, err_par);
    end
    reset = 1'b0;
    tick();
    po_ready = 1'b1;
    send_frame(32'h0000_0081, 2'd0, 1'b0, 0);
    tick();
    n_checks++;
    if (po_valid !== 1'b1 || po_data !== 32'h0000_0081 || err_short !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_after: got v=%b data=%h short=%b expected v=1 data=00000081 short=0",
                         po_valid, po_data, err_short);
    end
  endtask

  initial begin
    reset      = 1'b1;
    si_data    = 1'b0;
    si_valid   = 1'b0;
    cfg_length = 2'd0;
    cfg_msb    = 1'b0;
    po_ready   = 1'b0;
    err_clr    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_msb8();
    test_lsb32();
    test_short();
    test_long();
    test_overrun();
    test_back_to_back();
    test_parity();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sti_rx.md
# sti_rx

Serial-to-parallel receiver for the STI link: samples a one-bit stream qualified by a valid strobe, reassembles 8/16/24/32-bit words in MSB-first or LSB-first order, and presents them on a valid/ready parallel port. It is the receive end of the STI serial interface and sits between the link input and the downstream word consumer. It also detects short, long and overrun frames.

## Interface
- `LEN_W`, default 2: width of the length code; 00=8, 01=16, 10=24, 11=32 bits.
- `clk` in 1: single clock; all logic samples on the rising edge.
- `reset` in 1: synchronous, active-high.
- `si_data` in 1: serial bit.
- `si_valid` in 1: frame strobe; high for exactly one bit per cycle, contiguous within a frame.
- `cfg_length` in 2: frame length code; sampled on the first bit of each frame.
- `cfg_msb` in 1: 1 = MSB-first, 0 = LSB-first; sampled with `cfg_length`.
- `po_data` out 32: assembled word, right-justified, unused upper bits 0.
- `po_length` out 2: length code of the held word.
- `po_valid` out 1: word held.
- `po_ready` in 1: consumer accepts when `po_valid & po_ready`.
- `err_short` out 1: sticky; frame ended early.
- `err_long` out 1: sticky; strobe outlasted the frame.
- `err_ovr` out 1: sticky; a word was dropped because the holding register was full.
- `err_par` out 1: sticky; parity mismatch. Tied 0 without `STI_RX_PARITY_EN`.
- `err_clr` in 1: one-cycle clear of all sticky errors.

## Operation
- States: IDLE, SHIFT, PAR (parity build only), DRAIN.
- IDLE: `si_valid=1` latches `cfg_length` and `cfg_msb`, captures bit 0, sets `cnt=1`, and moves to SHIFT.
  - If N=1 were possible it would complete at once; the minimum N is 8, so it never is.
- SHIFT: each `si_valid=1` cycle captures one bit and increments the 6-bit `cnt`.
  - MSB-first: `sh <= {sh[30:0], si_data}`.
  - LSB-first: `sh[cnt] <= si_data`.
- Frame completes on the cycle the Nth bit is captured (N = 8·(code+1)).
  - Go to PAR if parity is enabled, otherwise to DRAIN.
  - Raise an internal `done` pulse.
- `si_valid=0` in SHIFT or PAR before completion: set `err_short`, discard the partial word, return to IDLE.
- DRAIN: wait for `si_valid=0`, then go to IDLE.
  - Any `si_valid=1` cycle seen in DRAIN sets `err_long`; those bits are ignored.
  - The frame's word is still delivered.
- Back-to-back frames need at least one idle cycle between them.
- `done` loads the holding register (`po_data` = `sh` masked to N bits, `po_length`, `po_valid=1`) on the following edge if the register is empty or is being accepted that cycle.
  - Otherwise the new word is dropped, `err_ovr` is set, and the held word is unchanged.
- `po_valid` falls on the edge where `po_ready=1`, unless a new load occurs on that same edge.
- Error set and `err_clr` on the same edge: set wins.

## Timing
- Reset values: `po_data=0`, `po_length=0`, `po_valid=0`, all `err_*=0`, state IDLE, `cnt=0`, `sh=0`.
- Reset mid-frame discards the partial word and the held word.
- Latency: last data bit (or parity bit) captured at edge E; `po_valid=1` is visible after edge E+1.
- `po_data` and `po_length` are stable while `po_valid=1 & po_ready=0`.
- Throughput: one word per N+1 cycles (N+2 with parity) at full rate.
- Config inputs are ignored outside the first bit of a frame.

## Configuration
- `STI_RX_PARITY_EN` defined:
  - Every frame carries one extra bit after the data: even parity over the N data bits.
  - PAR captures it and compares; on mismatch, `err_par` is set and the word is still delivered.
  - `si_valid=0` in PAR sets `err_short` and discards the word.
- `STI_RX_PARITY_EN` undefined: no PAR state, and `err_par` is constant 0.

## Structure
- Package `sti_pkg` holds:
  - Length code constants `STI_LEN8`, `STI_LEN16`, `STI_LEN24`, `STI_LEN32`.
  - Function `sti_len_bits(code)` returning 8/16/24/32.
  - State enum `sti_rx_state_t`.
- Sub-module `sti_rx_shifter`: shift register plus bit counter with MSB/LSB insertion and completion compare.
- The top level owns the FSM, holding register and error flags.

## Test plan
- 8-bit MSB-first, bits 1,0,1,1,0,0,1,0, `po_ready=1` -> `po_data=0x000000B2`, `po_length=00`, `po_valid` high one cycle, 1 cycle after the last bit.
- 32-bit LSB-first, serialized value 0xDEADBEEF sent LSB-first -> `po_data=0xDEADBEEF`, no errors.
- 16-bit frame with `si_valid` dropped after 10 bits -> `err_short=1`, no `po_valid`; a following 8-bit frame 0x5A is delivered correctly.
- 24-bit frame with `si_valid` held 27 cycles -> word delivered, `err_long=1`; `err_clr` pulse -> `err_long=0`.
- Two 8-bit frames 0x11 then 0x22 with `po_ready=0` -> `po_data` stays 0x11, `err_ovr=1`; raising `po_ready` accepts 0x11, then `po_valid=0`.
- Parity build: 8-bit 0x03 with parity bit 1 -> `err_par=1`, word 0x03 delivered; reset asserted mid-frame -> all outputs 0 on the next edge.
